// File: rtl/mod_n_counter_pkg.sv
// rtl/mod_n_counter_pkg.sv - shared defaults and width helper for mod_n_counter
package mod_n_counter_pkg;

  localparam int MODN_DEFAULT_N     = 10;
  localparam int MODN_DEFAULT_WIDTH = 4;

  // Smallest bit width able to hold every value 0..n-1.
  function automatic int modn_min_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - free-running modulo-N counter with terminal-count flag
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int N     = MODN_DEFAULT_N,
  parameter int WIDTH = MODN_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  if (N < 2 || WIDTH < modn_min_width(N)) begin : g_bad_param
    $error("mod_n_counter: illegal parameters N=%0d WIDTH=%0d", N, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Any value at or above LAST returns to zero, which also scrubs illegal power-up states.
  always_comb begin
    w_next = r_count + WIDTH'(1);
    if (r_count >= LAST) begin
      w_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign out = r_count;
  assign tc  = (r_count == LAST);

endmodule

// File: tb/tb_mod_n_counter.sv
// tb/tb_mod_n_counter.sv - directed scoreboard bench for mod_n_counter (N=10 and N=16)
module tb_mod_n_counter;

  logic       clk;
  logic       reset;
  logic [3:0] out10;
  logic       tc10;
  logic [3:0] out16;
  logic       tc16;

  mod_n_counter #(.N(10), .WIDTH(4)) u_dut10 (
    .clk  (clk),
    .reset(reset),
    .out  (out10),
    .tc   (tc10)
  );

  mod_n_counter #(.N(16), .WIDTH(4)) u_dut16 (
    .clk  (clk),
    .reset(reset),
    .out  (out16),
    .tc   (tc16)
  );

  typedef struct {
    int o10;
    int t10;
    int o16;
    int t16;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m10 = 0;
  int   m16 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Predict the post-edge state, push it, take the edge, then pop and compare.
  task automatic step();
    exp_t e;
    if (reset) begin
      m10 = 0;
      m16 = 0;
    end else begin
      m10 = (m10 == 9) ? 0 : m10 + 1;
      m16 = (m16 == 15) ? 0 : m16 + 1;
    end
    e.o10 = m10;
    e.t10 = (m10 == 9) ? 1 : 0;
    e.o16 = m16;
    e.t16 = (m16 == 15) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check("out_n10", int'(out10), e.o10);
      check("tc_n10",  int'(tc10),  e.t10);
      check("out_n16", int'(out16), e.o16);
      check("tc_n16",  int'(tc16),  e.t16);
    end
  endtask

  initial begin
    reset = 1'b1;
    #2;
    check("reset_async_out", int'(out10), 0);
    check("reset_async_tc",  int'(tc10),  0);

    step();
    step();
    #3;
    reset = 1'b0;

    for (int i = 0; i < 25; i++) step();
    step();

    reset = 1'b1;
    m10 = 0;
    m16 = 0;
    #1;
    check("midreset_out_n10", int'(out10), 0);
    check("midreset_tc_n10",  int'(tc10),  0);
    check("midreset_out_n16", int'(out16), 0);

    for (int i = 0; i < 3; i++) step();
    #3;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
